// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM states and flag bit positions
// for the sequential ALU core.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_ADC  = 4'h2;
  localparam logic [3:0] OP_SBC  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_MUL  = 4'h7;
  localparam logic [3:0] OP_SLL  = 4'h8;
  localparam logic [3:0] OP_SRL  = 4'h9;
  localparam logic [3:0] OP_SRA  = 4'hA;
  localparam logic [3:0] OP_PASS = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int FLG_Z = 3;
  localparam int FLG_N = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

endpackage

// File: rtl/alu_addsub.sv
// Ripple-carry adder with optional B inversion;
// reports carry-out and signed overflow.
module alu_addsub #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             invert_b,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             v
);

  logic [WIDTH-1:0] bx;
  logic             carry;
  logic             c_msb;

  assign bx = invert_b ? ~b : b;

  always_comb begin
    carry = cin;
    c_msb = 1'b0;
    sum   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i == WIDTH - 1) c_msb = carry;
      sum[i] = a[i] ^ bx[i] ^ carry;
      carry  = (a[i] & bx[i]) | (carry & (a[i] ^ bx[i]));
    end
  end

  assign cout = carry;
  assign v    = carry ^ c_msb;

endmodule

// File: rtl/alu_seq_core.sv
// Sequential ALU: accumulator, flag register, iterative
// shifts and shift-add multiply behind valid/ready.
module alu_seq_core
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             use_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             busy
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int CNT_W   = $clog2(WIDTH + 1);

  state_t             state;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic [WIDTH-1:0]   sh;
  logic [CNT_W-1:0]   cnt;

  logic               fire;
  logic [WIDTH-1:0]   opa_in;
  logic [SHAMT_W-1:0] n_in;
  logic               is_mul_in;
  logic               is_shift_in;

  logic [WIDTH-1:0]   ad_a;
  logic [WIDTH-1:0]   ad_b;
  logic               ad_cin;
  logic               ad_inv;
  logic [WIDTH-1:0]   ad_sum;
  logic               ad_cout;
  logic               ad_v;

  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_v;
  logic [WIDTH-1:0]   sh_nxt;
  logic               sh_c;
  logic [WIDTH-1:0]   hi_nxt;
  logic [WIDTH-1:0]   lo_nxt;

  logic               fin;
  logic [WIDTH-1:0]   fin_res;
  logic               fin_c;
  logic               fin_v;

  assign in_ready = !reset &&
    (state == ST_IDLE || (state == ST_DONE && out_ready));
  assign busy     = (state == ST_EXEC);
  assign fire     = in_valid && in_ready;
  assign opa_in   = use_acc ? acc : a;
  assign n_in     = b[SHAMT_W-1:0];

  assign is_mul_in   = (op == OP_MUL);
  assign is_shift_in = (op == OP_SLL) || (op == OP_SRL) ||
                       (op == OP_SRA);

  // One adder serves both accept-time add/sub and MUL steps
  always_comb begin
    ad_a   = opa_in;
    ad_b   = b;
    ad_cin = 1'b0;
    ad_inv = 1'b0;
    if (state == ST_EXEC) begin
      ad_a = hi;
      ad_b = lo[0] ? mcand : '0;
    end else begin
      unique case (op)
        OP_SUB: begin
          ad_inv = 1'b1;
          ad_cin = 1'b1;
        end
        OP_ADC: ad_cin = flags[FLG_C];
        OP_SBC: begin
          ad_inv = 1'b1;
          ad_cin = flags[FLG_C];
        end
        default: ;
      endcase
    end
  end

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a        (ad_a),
    .b        (ad_b),
    .cin      (ad_cin),
    .invert_b (ad_inv),
    .sum      (ad_sum),
    .cout     (ad_cout),
    .v        (ad_v)
  );

  always_comb begin
    alu_res = opa_in;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    unique case (op)
      OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
        alu_res = ad_sum;
        alu_c   = ad_cout;
        alu_v   = ad_v;
      end
      OP_AND:  alu_res = opa_in & b;
      OP_OR:   alu_res = opa_in | b;
      OP_XOR:  alu_res = opa_in ^ b;
      default: ;
    endcase
  end

  always_comb begin
    sh_nxt = sh;
    sh_c   = 1'b0;
    unique case (op_q)
      OP_SLL: begin
        sh_nxt = {sh[WIDTH-2:0], 1'b0};
        sh_c   = sh[WIDTH-1];
      end
      OP_SRL: begin
        sh_nxt = {1'b0, sh[WIDTH-1:1]};
        sh_c   = sh[0];
      end
      OP_SRA: begin
        sh_nxt = {sh[WIDTH-1], sh[WIDTH-1:1]};
        sh_c   = sh[0];
      end
      default: ;
    endcase
  end

  // Partial product and multiplier shift right together
  assign hi_nxt = {ad_cout, ad_sum[WIDTH-1:1]};
  assign lo_nxt = {ad_sum[0], lo[WIDTH-1:1]};

  always_comb begin
    fin     = 1'b0;
    fin_res = '0;
    fin_c   = 1'b0;
    fin_v   = 1'b0;
    if (state == ST_EXEC) begin
      fin = (cnt == CNT_W'(1));
      if (op_q == OP_MUL) begin
        fin_res = lo_nxt;
        fin_c   = |hi_nxt;
      end else begin
        fin_res = sh_nxt;
        fin_c   = sh_c;
      end
    end else if (fire) begin
      if (is_shift_in) begin
        fin     = (n_in == '0);
        fin_res = opa_in;
      end else if (!is_mul_in) begin
        fin     = 1'b1;
        fin_res = alu_res;
        fin_c   = alu_c;
        fin_v   = alu_v;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      op_q      <= OP_PASS;
      acc       <= '0;
      result    <= '0;
      flags     <= '0;
      out_valid <= 1'b0;
      cnt       <= '0;
      mcand     <= '0;
      hi        <= '0;
      lo        <= '0;
      sh        <= '0;
    end else begin
      if (state == ST_EXEC) begin
        cnt <= cnt - CNT_W'(1);
        if (op_q == OP_MUL) begin
          hi <= hi_nxt;
          lo <= lo_nxt;
        end else begin
          sh <= sh_nxt;
        end
      end else if (fire) begin
        op_q  <= op;
        mcand <= opa_in;
        sh    <= opa_in;
        hi    <= '0;
        lo    <= b;
        cnt   <= is_mul_in ? CNT_W'(WIDTH) : CNT_W'(n_in);
        if (!fin) begin
          state     <= ST_EXEC;
          out_valid <= 1'b0;
        end
      end else if (state == ST_DONE && out_ready) begin
        state     <= ST_IDLE;
        out_valid <= 1'b0;
      end
      if (fin) begin
        result    <= fin_res;
        acc       <= fin_res;
        flags     <= {fin_res == '0, fin_res[WIDTH-1], fin_c, fin_v};
        state     <= ST_DONE;
        out_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_core.sv
// Directed bench for alu_seq_core at WIDTH=8
// with hand-computed results, flags and latencies.
module tb_alu_seq_core;
  import alu_seq_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] op = 4'h0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       use_acc = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] result;
  logic [3:0] flags;
  logic       busy;

  int errs = 0;
  int checks = 0;

  alu_seq_core #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .use_acc   (use_acc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] o, input logic [7:0] av,
                      input logic [7:0] bv, input logic ua);
    int t = 0;
    while (!in_ready && t < 20) begin
      tick();
      t++;
    end
    if (!in_ready) check("send_ready", 0, 1);
    op = o;
    a = av;
    b = bv;
    use_acc = ua;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = 8'h5A;
    b = 8'hC3;
    use_acc = 1'b0;
  endtask

  task automatic wait_out(inout int lat);
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    if (!out_valid) check("out_timeout", 0, 1);
  endtask

  task automatic run(input string tag, input logic [3:0] o,
                     input logic [7:0] av, input logic [7:0] bv,
                     input logic ua, input logic [7:0] er,
                     input logic [3:0] ef, input int elat);
    int lat = 0;
    send(o, av, bv, ua);
    wait_out(lat);
    check({tag, "_res"}, result, er);
    check({tag, "_flg"}, flags, ef);
    check({tag, "_lat"}, lat, elat);
    tick();
  endtask

  initial begin
    int lat;
    bit seen;

    repeat (3) tick();
    check("rst_ready", in_ready, 0);
    reset = 1'b0;
    check("rst_ov", out_valid, 0);
    check("rst_res", result, 8'h00);
    check("rst_flg", flags, 4'b0000);
    tick();
    check("rst_ready_rel", in_ready, 1);

    run("add_ovf", OP_ADD, 8'h7F, 8'h01, 1'b0, 8'h80, 4'b0101, 0);
    run("sub_eq",  OP_SUB, 8'h05, 8'h05, 1'b0, 8'h00, 4'b1010, 0);
    run("add_cy",  OP_ADD, 8'hFF, 8'h01, 1'b0, 8'h00, 4'b1010, 0);
    run("adc_acc", OP_ADC, 8'hEE, 8'h00, 1'b1, 8'h01, 4'b0000, 0);
    run("sra3",    OP_SRA, 8'h80, 8'h03, 1'b0, 8'hF0, 4'b0100, 3);
    run("sll1",    OP_SLL, 8'h81, 8'h01, 1'b0, 8'h02, 4'b0010, 1);
    run("srl0",    OP_SRL, 8'h5A, 8'h00, 1'b0, 8'h5A, 4'b0000, 0);
    run("xor",     OP_XOR, 8'hF0, 8'hFF, 1'b0, 8'h0F, 4'b0000, 0);
    run("mul",     OP_MUL, 8'd13, 8'd11, 1'b0, 8'h8F, 4'b0100, 8);

    // MUL with a stray in_valid pulse while executing
    lat = 0;
    send(OP_MUL, 8'h10, 8'h10, 1'b0);
    tick();
    tick();
    lat = 2;
    op = OP_ADD;
    a = 8'h01;
    b = 8'h01;
    in_valid = 1'b1;
    check("exec_ready", in_ready, 0);
    check("exec_busy", busy, 1);
    tick();
    lat++;
    in_valid = 1'b0;
    wait_out(lat);
    check("mul_hi_res", result, 8'h00);
    check("mul_hi_flg", flags, 4'b1010);
    check("mul_hi_lat", lat, 8);
    tick();
    check("mul_hi_idle", out_valid, 0);
    check("mul_hi_nobusy", busy, 0);

    // Consumer stalls while DONE
    out_ready = 1'b0;
    lat = 0;
    send(OP_ADD, 8'h03, 8'h04, 1'b0);
    wait_out(lat);
    repeat (5) tick();
    check("stall_ov", out_valid, 1);
    check("stall_ready", in_ready, 0);
    check("stall_res", result, 8'h07);
    check("stall_flg", flags, 4'b0000);
    out_ready = 1'b1;
    tick();
    check("stall_rel", out_valid, 0);

    // Reset in the middle of a multiply
    send(OP_MUL, 8'h03, 8'h05, 1'b0);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      seen |= out_valid;
      tick();
    end
    check("abort_ov", seen, 0);
    check("abort_res", result, 8'h00);
    check("abort_flg", flags, 4'b0000);
    run("abort_acc", OP_ADC, 8'h77, 8'h00, 1'b1, 8'h00, 4'b1000, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
